fill_rect: RTL
==============

FILL_RECT -- requirements
Module: fill_rect

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 SHALL have parameter X_W, default 8, x coordinate width; SCREEN_W <= 2**X_W.
REQ-004 SHALL have parameter Y_W, default 7, y coordinate width; SCREEN_H <= 2**Y_W.
REQ-005 SHALL have parameter COLOUR_W, default 3, colour width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  request; held high until done seen.
REQ-009 SHALL have port mode  input  2  fill mode: 0 solid, 1 column stripe, 2 checker, 3 reserved (treated as solid).
REQ-010 SHALL have port colour  input  COLOUR_W  base fill colour.
REQ-011 SHALL have ports x0, x1  input  X_W  inclusive left/right column bounds.
REQ-012 SHALL have ports y0, y1  input  Y_W  inclusive top/bottom row bounds.
REQ-013 SHALL have port done  output  1  operation complete.
REQ-014 SHALL have port busy  output  1  high while pixels are being emitted.
REQ-015 SHALL have ports vga_x  output  X_W, vga_y  output  Y_W  current pixel coordinate.
REQ-016 SHALL have port vga_colour  output  COLOUR_W  current pixel colour.
REQ-017 SHALL have port vga_plot  output  1  pixel write strobe.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, FILL, DONE.
REQ-019 In IDLE with start=1 at a rising edge, SHALL latch mode, colour and clamped bounds (x1c=min(x1,SCREEN_W-1), y1c=min(y1,SCREEN_H-1)) and load vga_x=x0, vga_y=y0.
REQ-020 After latching, SHALL enter FILL if x0<=x1c and y0<=y1c, otherwise DONE directly with zero plots.
REQ-021 Inputs other than start SHALL be ignored outside the IDLE latch cycle.
REQ-022 In FILL, vga_plot=1 and busy=1 every cycle; exactly one pixel per cycle.
REQ-023 Scan order SHALL be column-major: y increments from y0 to y1c; at y1c, y reloads y0 and x increments.
REQ-024 FILL SHALL exit to DONE on the cycle the pixel (x1c,y1c) is plotted; total plots = (x1c-x0+1)*(y1c-y0+1).
REQ-025 vga_colour SHALL be: mode 0/3 colour; mode 1 colour XOR vga_x[COLOUR_W-1:0]; mode 2 colour if vga_x[0]==vga_y[0], else ~colour.
REQ-026 First plot SHALL occur the cycle after start is sampled; done SHALL rise the cycle after the last plot.
REQ-027 In DONE, done=1, busy=0, vga_plot=0; remain until start=0, then return to IDLE (done falls same edge).
REQ-028 If start is still high in IDLE after DONE→IDLE, a new operation SHALL NOT begin until start has been low at least one sampled edge (no re-trigger from a held start).
REQ-029 Counter comparisons SHALL be done at full X_W/Y_W width with no wrap; x0 or y0 beyond screen SHALL yield the empty case.
REQ-030 vga_plot SHALL never assert with coordinates outside SCREEN_W x SCREEN_H.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, latched regs=0, re-arm flag cleared.
REQ-032 Reset mid-FILL SHALL abort immediately with no further plots; first start after release behaves as fresh.

Structure
REQ-033 Shared package fill_pkg SHALL hold FSM state enum and mode encodings (MODE_SOLID, MODE_STRIPE, MODE_CHECK).
REQ-034 Colour pattern generation SHALL be a combinational sub-module fill_pattern (mode, colour, x, y -> pixel colour).
REQ-035 Implementation SHALL be single-clock, no latches, no multicycle paths.

Verification
REQ-036 Defaults, mode 0, colour 3'b101, bounds (0,0)-(159,119) -> 19200 plots, all colour 101, done 19201 cycles after start sampled.
REQ-037 Bounds (10,20)-(12,21), mode 0 -> plots exactly (10,20),(10,21),(11,20),(11,21),(12,20),(12,21) in order, then done.
REQ-038 Bounds (150,110)-(200,127) -> clamped to (150..159,110..119), 100 plots, none out of screen.
REQ-039 x0=5>x1=4 -> zero plots, done one cycle after start sampled; start held high after done/low cycle -> no second operation until low edge seen.
REQ-040 Mode 1 colour 3'b000 on (0,0)-(7,0) -> colours 0..7; mode 2 colour 3'b010 on (0,0)-(1,1) -> 010,101,101,010.
REQ-041 rst_n pulsed low after 50 plots of a full fill -> vga_plot low asynchronously, outputs at reset values; subsequent start gives a full correct fill.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared types for the rectangle filler: FSM state and fill-mode encodings.
package fill_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SOLID  = 2'd0;
  localparam logic [1:0] MODE_STRIPE = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

endpackage

// File: rtl/fill_rect_if.sv
// Request/pixel bus between a fill requester (master) and fill_rect (slave).
interface fill_rect_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic                start;
  logic [1:0]          mode;
  logic [COLOUR_W-1:0] colour;
  logic [X_W-1:0]      x0, x1;
  logic [Y_W-1:0]      y0, y1;
  logic                done;
  logic                busy;
  logic [X_W-1:0]      vga_x;
  logic [Y_W-1:0]      vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;

  modport master (
    output start, mode, colour, x0, x1, y0, y1,
    input  done, busy, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, mode, colour, x0, x1, y0, y1,
    output done, busy, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/fill_pattern.sv
// Combinational pixel colour generator: solid, column stripe or checkerboard.
module fill_pattern
  import fill_pkg::*;
#(
  parameter int COLOUR_W = 3
) (
  input  logic [1:0]          mode,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [COLOUR_W-1:0] x_lo,
  input  logic                y_lsb,
  output logic [COLOUR_W-1:0] pix
);

  always_comb begin
    pix = colour;
    case (mode)
      MODE_STRIPE: pix = colour ^ x_lo;
      MODE_CHECK:  pix = (x_lo[0] == y_lsb) ? colour : ~colour;
      default:     pix = colour;  // solid and reserved
    endcase
  end

endmodule

// File: rtl/fill_rect.sv
// Rectangle filler: emits one pixel per cycle, column-major, over a clamped box.
module fill_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input logic        clk,
  input logic        rst_n,
  fill_rect_if.slave bus
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  state_t              state;
  logic [1:0]          mode_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [Y_W-1:0]      y0_q;
  logic [X_W-1:0]      x1c_q;
  logic [Y_W-1:0]      y1c_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic                done_q, busy_q, plot_q;
  // Set when a request is taken; only a sampled low start clears it.
  logic                hold_off;

  logic [X_W-1:0] x1c;
  logic [Y_W-1:0] y1c;
  logic           empty;

  assign x1c   = (bus.x1 > X_MAX) ? X_MAX : bus.x1;
  assign y1c   = (bus.y1 > Y_MAX) ? Y_MAX : bus.y1;
  // Off-screen origins fall out here because the clamped far edge is below them.
  assign empty = (bus.x0 > x1c) || (bus.y0 > y1c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      colour_q <= '0;
      y0_q     <= '0;
      x1c_q    <= '0;
      y1c_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      plot_q   <= 1'b0;
      hold_off <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.start) begin
            hold_off <= 1'b0;
          end else if (!hold_off) begin
            hold_off <= 1'b1;
            mode_q   <= bus.mode;
            colour_q <= bus.colour;
            y0_q     <= bus.y0;
            x1c_q    <= x1c;
            y1c_q    <= y1c;
            x_q      <= bus.x0;
            y_q      <= bus.y0;
            if (empty) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state  <= S_FILL;
              busy_q <= 1'b1;
              plot_q <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (x_q == x1c_q && y_q == y1c_q) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            plot_q <= 1'b0;
            done_q <= 1'b1;
          end else if (y_q == y1c_q) begin
            y_q <= y0_q;
            x_q <= x_q + 1'b1;
          end else begin
            y_q <= y_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state    <= S_IDLE;
            done_q   <= 1'b0;
            hold_off <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.vga_plot = plot_q;
  assign bus.vga_x    = x_q;
  assign bus.vga_y    = y_q;

  // Stripe/checker only look at the low x bits; COLOUR_W must not exceed X_W.
  fill_pattern #(.COLOUR_W(COLOUR_W)) u_pattern (
    .mode   (mode_q),
    .colour (colour_q),
    .x_lo   (x_q[COLOUR_W-1:0]),
    .y_lsb  (y_q[0]),
    .pix    (bus.vga_colour)
  );

endmodule
